// File: rtl/detector_test_sequencer.sv
// Test sequencer for the Moore sequence detector: clears it, plays a latched
// pattern MSB-first at a programmable pace and records the detector output per bit.
module detector_test_sequencer #(
  parameter int STEP_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] pattern,
  input  logic [4:0]  length,
  input  logic        det_out,
  output logic        det_w,
  output logic        det_en,
  output logic        det_resetn,
  output logic        busy,
  output logic        done,
  output logic [15:0] hit_map,
  output logic [4:0]  hit_count,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WAIT   = 3'd2,
    STEP   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       pat;
  logic [4:0]        len;
  logic [3:0]        idx;
  logic [DIV_W-1:0]  divider;

  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return (l > 5'd16) ? 5'd16 : l;
  endfunction

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length != 5'd0) ? CLEAR : DONE;
      CLEAR:   state_next = WAIT;
      WAIT:    if (divider == DIV_LAST) state_next = STEP;
      STEP:    state_next = SAMPLE;
      SAMPLE:  state_next = (idx == 4'd0) ? DONE : WAIT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort wins over every transition out of a busy state
    if (abort && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pat       <= '0;
      len       <= '0;
      idx       <= '0;
      divider   <= '0;
      hit_map   <= '0;
      hit_count <= '0;
    end else if (!(abort && state != IDLE)) begin
      case (state)
        IDLE: begin
          if (start && length != 5'd0) begin
            pat <= pattern;
            len <= clamp_len(length);
          end else if (start) begin
            hit_map   <= '0;
            hit_count <= '0;
          end
        end
        CLEAR: begin
          hit_map   <= '0;
          hit_count <= '0;
          idx       <= 4'(len - 5'd1);
          divider   <= '0;
        end
        WAIT: begin
          if (divider == DIV_LAST) divider <= '0;
          else                     divider <= divider + 1'b1;
        end
        SAMPLE: begin
          if (det_out) begin
            hit_map[idx] <= 1'b1;
            hit_count    <= hit_count + 5'd1;
          end
          if (idx != 4'd0) idx <= idx - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign det_en     = (state == STEP);
  assign det_w      = (state == STEP) ? pat[idx] : 1'b0;
  assign det_resetn = resetn && (state != CLEAR);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign state_out  = state;

endmodule

// File: tb/tb_detector_test_sequencer.sv
// Bench for detector_test_sequencer: two instances (STEP_DIV=1 and 4), each
// driving a behavioural Moore detector that recognises the last four inputs 11x1.
module tb_detector_test_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0, abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;

  logic        det_out1, det_w1, det_en1, det_resetn1, busy1, done1;
  logic [15:0] hit_map1;
  logic [4:0]  hit_count1;
  logic [2:0]  state1;
  logic        det_out4, det_w4, det_en4, det_resetn4, busy4, done4;
  logic [15:0] hit_map4;
  logic [4:0]  hit_count4;
  logic [2:0]  state4;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int en_cnt = 0;
  logic [15:0] en_bits = '0;

  typedef struct {
    logic [15:0] map;
    logic [4:0]  cnt;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  detector_test_sequencer #(.STEP_DIV(1), .DIV_W(8)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .abort(abort),
    .pattern(pattern), .length(length), .det_out(det_out1), .det_w(det_w1),
    .det_en(det_en1), .det_resetn(det_resetn1), .busy(busy1), .done(done1),
    .hit_map(hit_map1), .hit_count(hit_count1), .state_out(state1));

  detector_test_sequencer #(.STEP_DIV(4), .DIV_W(8)) dut4 (
    .clock(clock), .resetn(resetn), .start(start4), .abort(abort),
    .pattern(pattern), .length(length), .det_out(det_out4), .det_w(det_w4),
    .det_en(det_en4), .det_resetn(det_resetn4), .busy(busy4), .done(done4),
    .hit_map(hit_map4), .hit_count(hit_count4), .state_out(state4));

  // Stand-in detectors: shift register of the last four played bits
  logic [3:0] sr1 = '0, sr4 = '0;
  always @(posedge clock) begin
    if (!det_resetn1)  sr1 <= '0;
    else if (det_en1)  sr1 <= {sr1[2:0], det_w1};
    if (!det_resetn4)  sr4 <= '0;
    else if (det_en4)  sr4 <= {sr4[2:0], det_w4};
  end
  assign det_out1 = sr1[3] & sr1[2] & sr1[0];
  assign det_out4 = sr4[3] & sr4[2] & sr4[0];

  always @(negedge clock) begin
    if (det_en1) begin
      en_cnt++;
      en_bits = {en_bits[14:0], det_w1};
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy1, done1, det_en1, det_w1, det_resetn1} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy1, done1, det_en1, det_w1, det_resetn1});
    end
    checks++;
    if (hit_map1 !== 16'h0 || hit_count1 !== 5'd0 || state1 !== 3'd0) begin
      errors++; $display("FAIL reset_data: map=%h cnt=%0d st=%0d want 0", hit_map1, hit_count1, state1);
    end
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (det_resetn1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_release: det_resetn=%b busy=%b want 1 0", det_resetn1, busy1);
    end
  endtask

  task automatic run_seq(input logic [15:0] p, input logic [4:0] l,
                         input logic [15:0] emap, input logic [4:0] ecnt);
    int n, budget;
    logic [16:0] mask;
    exp_t e;
    n = (l > 5'd16) ? 16 : int'(l);
    @(negedge clock);
    pattern = p; length = l; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; pattern = ~p; length = 5'd3;
    en_cnt = 0; en_bits = '0;
    // done becomes visible 1+N*(STEP_DIV+2) edges after the accepting edge
    sb.push_back('{map: emap, cnt: ecnt, due: edge_cnt + ((n == 0) ? 0 : 1 + n * 3)});
    checks++;
    if (n != 0 && (state1 !== 3'd1 || det_resetn1 !== 1'b0 || busy1 !== 1'b1)) begin
      errors++; $display("FAIL clear_state: st=%0d det_resetn=%b busy=%b want 1 0 1", state1, det_resetn1, busy1);
    end else if (n == 0 && (state1 !== 3'd5 || done1 !== 1'b1)) begin
      errors++; $display("FAIL zero_len_done: st=%0d done=%b want 5 1", state1, done1);
    end
    budget = 0;
    while (done1 !== 1'b1 && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    e = sb.pop_front();
    checks++;
    if (done1 !== 1'b1) begin
      errors++; $display("FAIL done_timeout: no done within %0d cycles", budget);
      return;
    end
    if (edge_cnt !== e.due) begin
      errors++; $display("FAIL latency: done at edge %0d want %0d", edge_cnt, e.due);
    end
    checks++;
    if (hit_map1 !== e.map || hit_count1 !== e.cnt) begin
      errors++; $display("FAIL hits: map=%h cnt=%0d want map=%h cnt=%0d", hit_map1, hit_count1, e.map, e.cnt);
    end
    mask = (17'd1 << n) - 17'd1;
    checks++;
    if (en_cnt != n || en_bits !== (p & mask[15:0])) begin
      errors++; $display("FAIL det_w_seq: steps=%0d bits=%h want steps=%0d bits=%h", en_cnt, en_bits, n, p & mask[15:0]);
    end
    @(negedge clock);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || hit_map1 !== e.map) begin
      errors++; $display("FAIL after_done: done=%b busy=%b map=%h want 0 0 %h", done1, busy1, hit_map1, e.map);
    end
  endtask

  task automatic test_patterns();
    run_seq(16'h000F, 5'd4, 16'h0001, 5'd1);
    run_seq(16'h001F, 5'd5, 16'h0003, 5'd2);
    run_seq(16'h000D, 5'd4, 16'h0001, 5'd1);
    run_seq(16'h0000, 5'd8, 16'h0000, 5'd0);
    run_seq(16'hFFFF, 5'd20, 16'h1FFF, 5'd13);
  endtask

  task automatic test_len_zero();
    run_seq(16'hFFFF, 5'd0, 16'h0000, 5'd0);
  endtask

  task automatic test_abort();
    int waits, b;
    bit seen_done;
    @(negedge clock);
    pattern = 16'h00FF; length = 5'd8; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    waits = 0; b = 0;
    while (waits < 3 && b < 100) begin
      @(negedge clock);
      b++;
      if (state1 == 3'd2) waits++;
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (state1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || det_en1 !== 1'b0) begin
      errors++; $display("FAIL abort_idle: st=%0d busy=%b done=%b en=%b want 0 0 0 0", state1, busy1, done1, det_en1);
    end
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (done1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || hit_map1 !== 16'h0 || hit_count1 !== 5'd0) begin
      errors++; $display("FAIL abort_hold: done_seen=%b map=%h cnt=%0d want 0 0000 0", seen_done, hit_map1, hit_count1);
    end
    run_seq(16'h000F, 5'd4, 16'h0001, 5'd1);
  endtask

  task automatic test_back_to_back();
    int b, last, pulses, bad;
    exp_t e;
    @(negedge clock);
    pattern = 16'hFFFF; length = 5'd16; start4 = 1'b1;
    @(negedge clock);
    pattern = 16'h0000;
    sb.push_back('{map: 16'h1FFF, cnt: 5'd13, due: edge_cnt + 1 + 16 * 6});
    b = 0; last = -1; pulses = 0; bad = 0;
    while (done4 !== 1'b1 && b < 500) begin
      @(negedge clock);
      b++;
      if (det_en4) begin
        if (last >= 0 && edge_cnt - last != 6) bad++;
        last = edge_cnt;
        pulses++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (pulses != 16 || bad != 0) begin
      errors++; $display("FAIL step_spacing: pulses=%0d bad_gaps=%0d want 16 0", pulses, bad);
    end
    checks++;
    if (done4 !== 1'b1 || edge_cnt !== e.due || hit_map4 !== e.map || hit_count4 !== e.cnt) begin
      errors++; $display("FAIL div4_run: done=%b edge=%0d map=%h cnt=%0d want 1 %0d %h %0d",
                         done4, edge_cnt, hit_map4, hit_count4, e.due, e.map, e.cnt);
    end
    @(negedge clock);
    checks++;
    if (state4 !== 3'd0) begin
      errors++; $display("FAIL rearm_idle: st=%0d want 0", state4);
    end
    @(negedge clock);
    checks++;
    if (state4 !== 3'd1 || busy4 !== 1'b1) begin
      errors++; $display("FAIL rearm_clear: st=%0d busy=%b want 1 1", state4, busy4);
    end
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy4, done4, det_en4, det_w4, det_resetn4} !== 5'b0 || hit_map4 !== 16'h0 ||
        hit_count4 !== 5'd0 || state4 !== 3'd0) begin
      errors++; $display("FAIL midrun_reset: ctrl=%b map=%h cnt=%0d st=%0d want 0",
                         {busy4, done4, det_en4, det_w4, det_resetn4}, hit_map4, hit_count4, state4);
    end
    start4 = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_len_zero();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
